// File: rtl/next_piece_queue.sv
// next_piece_queue
//   Keeps a short preview queue of upcoming tetromino types. The queue is filled
//   from a free-running random piece value. A repeat filter limits how many
//   identical pieces can be pushed back to back. The head piece is handed to the
//   game controller over a level request / one-cycle acknowledge handshake.
//
// Ports
//   clka         in   system clock, all state updates on the rising edge
//   restart_n    in   asynchronous reset, active-low
//   random       in   [PW-1:0] random piece value (changes on the falling edge)
//   spawn_req    in   level request for the next piece
//   spawn_ack    out  one-cycle pulse, spawn_piece is valid in this cycle
//   spawn_piece  out  [PW-1:0] piece popped on the last ack, held until the next ack
//   preview      out  [DEPTH*PW-1:0] queue contents, entry 0 (next piece) in the low bits
//   count        out  number of valid queue entries
//   ready        out  queue is full and waiting for a request
module next_piece_queue #(
  parameter int DEPTH      = 3,
  parameter int PW         = 2,
  parameter int MAX_REPEAT = 2
) (
  input  logic                       clka,
  input  logic                       restart_n,
  input  logic [PW-1:0]              random,
  input  logic                       spawn_req,
  output logic                       spawn_ack,
  output logic [PW-1:0]              spawn_piece,
  output logic [DEPTH*PW-1:0]        preview,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(MAX_REPEAT + 1);

  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST    = CW'(DEPTH - 1);
  localparam logic [RW-1:0] RUN_LIMIT = RW'(MAX_REPEAT);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_READY = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   entries_q [DEPTH];
  logic [PW-1:0]   entries_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   last_q, last_d;
  logic [RW-1:0]   run_q, run_d;
  logic            ack_q, ack_d;
  logic [PW-1:0]   piece_q, piece_d;

  logic            accept;
  logic            push;
  logic            pop;

  // A sample is refused only when it would extend a run that has already hit
  // the limit. run_q is 0 after reset, so the first sample always gets through.
  assign accept = !((random == last_q) && (run_q >= RUN_LIMIT));

  // Control: decides whether this edge pushes, pops, or only moves the state.
  // A push during S_ACK can leave the queue full on return to S_FILL. In that
  // case S_FILL moves on to S_READY without sampling, so count stays <= DEPTH.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_FILL: begin
        if (count_q == FULL) begin
          state_d = S_READY;
        end else if (accept) begin
          push = 1'b1;
          if (count_q == ALMOST) begin
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        if (spawn_req) begin
          pop     = 1'b1;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (accept && (count_q != FULL)) begin
          push = 1'b1;
        end
        state_d = S_FILL;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // Datapath: queue storage, occupancy, handed-out piece and repeat history.
  // Push and pop never happen in the same cycle, because pop is only done in S_READY.
  // The repeat history is left alone by pops. Only an accepted push changes it.
  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    last_d    = last_q;
    run_d     = run_q;
    piece_d   = piece_q;

    if (pop) begin
      piece_d = entries_q[0];
      for (int i = 0; i < DEPTH - 1; i++) begin
        entries_d[i] = entries_q[i+1];
      end
      entries_d[DEPTH-1] = '0;
      count_d = count_q - CW'(1);
    end

    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count_q == CW'(i)) begin
          entries_d[i] = random;
        end
      end
      count_d = count_q + CW'(1);
      if (random == last_q) begin
        if (run_q < RUN_LIMIT) begin
          run_d = run_q + RW'(1);
        end
      end else begin
        run_d = RW'(1);
      end
      last_d = random;
    end
  end

  // Register bank. Reset puts the block back into an empty S_FILL and clears
  // the repeat history. It also drops an ack that is in flight.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= S_FILL;
      count_q <= '0;
      last_q  <= '0;
      run_q   <= '0;
      ack_q   <= 1'b0;
      piece_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      run_q   <= run_d;
      ack_q   <= ack_d;
      piece_q <= piece_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  // Pack the queue entries into the preview bus, with entry 0 in the low bits.
  always_comb begin
    preview = '0;
    for (int i = 0; i < DEPTH; i++) begin
      preview[PW*i +: PW] = entries_q[i];
    end
  end

  assign spawn_ack   = ack_q;
  assign spawn_piece = piece_q;
  assign count       = count_q;
  assign ready       = (state_q == S_READY);

endmodule

// File: tb/tb_next_piece_queue.sv
module tb_next_piece_queue;

  localparam int DEPTH = 3;
  localparam int PW    = 2;
  localparam int MAXR  = 2;

  localparam int M_FILL  = 0;
  localparam int M_READY = 1;
  localparam int M_ACK   = 2;

  logic                 clka = 1'b0;
  logic                 restart_n = 1'b0;
  logic [PW-1:0]        random = '0;
  logic                 spawn_req = 1'b0;
  logic                 spawn_ack;
  logic [PW-1:0]        spawn_piece;
  logic [DEPTH*PW-1:0]  preview;
  logic [1:0]           count;
  logic                 ready;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: a queue of piece values plus the handshake phase and repeat history
  int mq[$];
  int mState;
  int mAck;
  int mPiece;
  int mLast;
  int mRun;

  typedef struct {
    logic [1:0] r;
    logic       q;
    int         expCount;
    int         expPreview;
    int         expReady;
    int         expAck;
    int         expPiece;
  } vec_t;

  vec_t vecs[7];

  next_piece_queue #(.DEPTH(DEPTH), .PW(PW), .MAX_REPEAT(MAXR)) dut (
    .clka        (clka),
    .restart_n   (restart_n),
    .random      (random),
    .spawn_req   (spawn_req),
    .spawn_ack   (spawn_ack),
    .spawn_piece (spawn_piece),
    .preview     (preview),
    .count       (count),
    .ready       (ready)
  );

  always #5 clka = ~clka;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    mq.delete();
    mState = M_FILL;
    mAck   = 0;
    mPiece = 0;
    mLast  = 0;
    mRun   = 0;
  endtask

  function automatic int modelPreview();
    int p = 0;
    foreach (mq[i]) p = p | (mq[i] << (PW * i));
    return p;
  endfunction

  task automatic modelPush(input int r);
    mq.push_back(r);
    if (r == mLast) mRun = (mRun + 1 > MAXR) ? MAXR : mRun + 1;
    else mRun = 1;
    mLast = r;
  endtask

  task automatic modelStep(input int r, input int q);
    bit acc;
    int nextAck;
    acc = !(r == mLast && mRun >= MAXR);
    nextAck = 0;
    case (mState)
      M_FILL: begin
        if (mq.size() == DEPTH) mState = M_READY;
        else if (acc) begin
          modelPush(r);
          if (mq.size() == DEPTH) mState = M_READY;
        end
      end
      M_READY: begin
        if (q != 0) begin
          mPiece  = mq.pop_front();
          nextAck = 1;
          mState  = M_ACK;
        end
      end
      default: begin
        if (acc && mq.size() < DEPTH) modelPush(r);
        mState = M_FILL;
      end
    endcase
    mAck = nextAck;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " count"}, 32'(count), mq.size());
    checkOutput({tag, " preview"}, 32'(preview), modelPreview());
    checkOutput({tag, " ready"}, 32'(ready), (mState == M_READY) ? 1 : 0);
    checkOutput({tag, " spawn_ack"}, 32'(spawn_ack), mAck);
    checkOutput({tag, " spawn_piece"}, 32'(spawn_piece), mPiece);
  endtask

  // Called at a falling edge. Drives the inputs, lets one rising edge pass, and
  // returns at the next falling edge.
  task automatic applyStimulus(input logic [1:0] r, input logic q);
    random    = r;
    spawn_req = q;
    @(posedge clka);
    modelStep(int'(r), int'(q));
    @(negedge clka);
  endtask

  task automatic applyReset(input logic q);
    restart_n = 1'b0;
    random    = '0;
    spawn_req = q;
    @(negedge clka);
    @(negedge clka);
    checkOutput("reset count", 32'(count), 0);
    checkOutput("reset preview", 32'(preview), 0);
    checkOutput("reset spawn_ack", 32'(spawn_ack), 0);
    checkOutput("reset spawn_piece", 32'(spawn_piece), 0);
    checkOutput("reset ready", 32'(ready), 0);
    restart_n = 1'b1;
    resetModel();
  endtask

  initial begin
    int prevR;
    logic [1:0] r;
    logic q;

    // Fill 1,2,3, pop one, refill with 0, then idle in READY
    vecs[0] = '{2'd1, 1'b0, 1, 1,  0, 0, 0};
    vecs[1] = '{2'd2, 1'b0, 2, 9,  0, 0, 0};
    vecs[2] = '{2'd3, 1'b0, 3, 57, 1, 0, 0};
    vecs[3] = '{2'd0, 1'b1, 2, 14, 0, 1, 1};
    vecs[4] = '{2'd0, 1'b0, 3, 14, 0, 0, 1};
    vecs[5] = '{2'd1, 1'b0, 3, 14, 1, 0, 1};
    vecs[6] = '{2'd1, 1'b0, 3, 14, 1, 0, 1};

    resetModel();
    applyReset(1'b0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].q);
      checkOutput($sformatf("vec%0d count", i), 32'(count), vecs[i].expCount);
      checkOutput($sformatf("vec%0d preview", i), 32'(preview), vecs[i].expPreview);
      checkOutput($sformatf("vec%0d ready", i), 32'(ready), vecs[i].expReady);
      checkOutput($sformatf("vec%0d spawn_ack", i), 32'(spawn_ack), vecs[i].expAck);
      checkOutput($sformatf("vec%0d spawn_piece", i), 32'(spawn_piece), vecs[i].expPiece);
    end

    // Repeat filter: six 2s give only two pushes, then a different value fills the queue
    applyReset(1'b0);
    repeat (6) applyStimulus(2'd2, 1'b0);
    checkOutput("T2 count capped", 32'(count), 2);
    checkOutput("T2 ready low", 32'(ready), 0);
    checkOutput("T2 preview", 32'(preview), 10);
    checkModel("T2a");
    applyStimulus(2'd0, 1'b0);
    checkOutput("T2 count full", 32'(count), 3);
    checkOutput("T2 entry2", 32'((preview >> 4) & 6'd3), 0);
    checkOutput("T2 ready", 32'(ready), 1);

    // Request held high from reset is served once the queue is ready
    applyReset(1'b1);
    applyStimulus(2'd0, 1'b1);
    checkOutput("T4 no ack 1", 32'(spawn_ack), 0);
    applyStimulus(2'd1, 1'b1);
    checkOutput("T4 no ack 2", 32'(spawn_ack), 0);
    applyStimulus(2'd2, 1'b1);
    checkOutput("T4 no ack 3", 32'(spawn_ack), 0);
    checkOutput("T4 ready", 32'(ready), 1);
    applyStimulus(2'd3, 1'b1);
    checkOutput("T4 ack", 32'(spawn_ack), 1);
    checkOutput("T4 piece", 32'(spawn_piece), 0);
    checkModel("T4a");
    applyStimulus(2'd3, 1'b0);
    checkOutput("T4 ack pulse ends", 32'(spawn_ack), 0);
    checkModel("T4b");

    // Async reset during the ack cycle
    applyReset(1'b0);
    applyStimulus(2'd1, 1'b0);
    applyStimulus(2'd2, 1'b0);
    applyStimulus(2'd3, 1'b0);
    applyStimulus(2'd0, 1'b1);
    checkOutput("T5 ack before reset", 32'(spawn_ack), 1);
    #2 restart_n = 1'b0;
    #1;
    checkOutput("T5 ack dropped", 32'(spawn_ack), 0);
    checkOutput("T5 count cleared", 32'(count), 0);
    checkOutput("T5 preview cleared", 32'(preview), 0);
    checkOutput("T5 ready cleared", 32'(ready), 0);
    resetModel();
    @(negedge clka);
    restart_n = 1'b1;
    applyStimulus(2'd3, 1'b0);
    applyStimulus(2'd0, 1'b0);
    applyStimulus(2'd1, 1'b0);
    checkOutput("T5 refill count", 32'(count), 3);
    checkModel("T5a");

    // Repeat history survives a pop
    applyReset(1'b0);
    applyStimulus(2'd1, 1'b0);
    applyStimulus(2'd3, 1'b0);
    applyStimulus(2'd3, 1'b0);
    applyStimulus(2'd0, 1'b1);
    checkOutput("T6 pop piece", 32'(spawn_piece), 1);
    applyStimulus(2'd3, 1'b0);
    checkOutput("T6 reject in ack", 32'(count), 2);
    applyStimulus(2'd3, 1'b0);
    checkOutput("T6 reject in fill", 32'(count), 2);
    applyStimulus(2'd0, 1'b0);
    checkOutput("T6 accept other", 32'(count), 3);
    checkOutput("T6 preview", 32'(preview), 15);
    checkModel("T6a");

    // Randomized run against the reference model, biased toward repeated values
    applyReset(1'b0);
    prevR = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) r = 2'(prevR);
      else r = 2'($urandom_range(0, 3));
      q = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      prevR = int'(r);
      applyStimulus(r, q);
      checkModel($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
